// File: rtl/upsample_unit_if.sv
// upsample_unit_if: input and output valid/ready streams of the upsampler
interface upsample_unit_if;
  logic mode;
  logic in_valid;
  logic in_ready;
  logic signed [7:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic signed [7:0] out_data;
  logic out_last;
  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/upsample_unit.sv
// upsample_unit: streams each sample out FACTOR times, repeated or zero-inserted
module upsample_unit #(
  parameter int FACTOR = 4
) (
  input logic clk,
  input logic rst_n,
  upsample_unit_if.slave bus
);
  localparam int CW = $clog2(FACTOR);
  localparam logic [CW-1:0] LAST = CW'(FACTOR - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  logic [0:0] state;
  logic signed [7:0] data_q;
  logic mode_q;
  logic last_q;
  logic [CW-1:0] cnt;
  logic out_valid;
  logic in_ready;
  logic last_rep;
  logic xfer;
  assign last_rep = cnt == LAST;
  assign out_valid = state == EMIT;
  assign xfer = out_valid && bus.out_ready;
  assign in_ready = state == IDLE || (xfer && last_rep);
  assign bus.out_valid = out_valid;
  assign bus.in_ready = in_ready;
  assign bus.out_data = (!mode_q || cnt == '0) ? data_q : 8'sd0;
  assign bus.out_last = last_q && last_rep;
  // load on accept, advance replica count on each transfer, idle after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data_q <= '0;
      mode_q <= 1'b0;
      last_q <= 1'b0;
      cnt <= '0;
    end else if (bus.in_valid && in_ready) begin
      state <= EMIT;
      data_q <= bus.in_data;
      mode_q <= bus.mode;
      last_q <= bus.in_last;
      cnt <= '0;
    end else if (xfer) begin
      state <= last_rep ? IDLE : EMIT;
      cnt <= last_rep ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: doc/upsample_unit.md
# upsample_unit

Streaming 1-D upsampler for the ECG feature path: the inverse of the 4:1 max-pooling stage, used in decoder/segmentation layers to restore time resolution. Each accepted signed 8-bit sample is expanded into FACTOR output samples, either by repetition (nearest-neighbour) or by zero insertion. Both sides use valid/ready handshakes. At most one sample is in flight, and full output throughput is sustained when the consumer never stalls.

## Interface
- FACTOR, 4, upsampling ratio, legal range 2..8; replica counter width is clog2(FACTOR).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = repeat sample, 1 = zero-insert; sampled only when an input is accepted.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle (combinational from state and output handshake).
- in_data  in  8  signed input sample.
- in_last  in  1  marks the final sample of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  8  signed output sample.
- out_last  out  1  final output of a frame.

## Operation
- State: IDLE (no held sample) or EMIT. Registers: data_q[7:0], mode_q, last_q, cnt.
- Input accept = in_valid && in_ready. On accept: data_q <= in_data, mode_q <= mode, last_q <= in_last, cnt <= 0, state <= EMIT.
- Output transfer = out_valid && out_ready.
- out_valid = (state == EMIT).
- out_data = data_q when mode_q == 0 or cnt == 0; otherwise 8'sd0. The output is a mux driven only from registers.
- out_last = last_q && (cnt == FACTOR-1).
- in_ready = (state == IDLE) || (out_valid && out_ready && cnt == FACTOR-1). This allows a new sample to load in the same cycle the final replica leaves.
- Transfer with cnt < FACTOR-1: cnt <= cnt + 1.
- Transfer with cnt == FACTOR-1 and in_valid: load the new sample (see accept), stay in EMIT.
- Transfer with cnt == FACTOR-1 and no in_valid: cnt <= 0, state <= IDLE.
- No transfer (out_ready low): all registers hold, so out_data, out_last and cnt stay stable.
- No arithmetic on data. Signed values pass bit-exact; -128 and 127 are unchanged.

## Timing
- Reset values:
  - state IDLE, cnt 0, data_q 0, mode_q 0, last_q 0.
  - Outputs: out_valid 0, out_data 0, out_last 0, in_ready 1.
- Latency: a sample accepted at edge k produces its first replica with out_valid high in the cycle after edge k.
- Throughput with out_ready held high: one output per cycle, and in_ready pulses high for one cycle in every FACTOR.
- A sample offered while in EMIT with cnt < FACTOR-1 is stalled (in_ready 0). The upstream holds in_data/in_last per handshake rules.
- mode or in_last changes while a sample is held have no effect until the next accept.
- Mid-operation reset: out_valid drops immediately (asynchronous). The held sample and remaining replicas are discarded. After release the block is in IDLE with in_ready 1.
- Frame boundary: after the out_last transfer, the next accepted sample starts a new frame without a bubble.

## Test plan
- Repeat mode, FACTOR 4, inputs 10, -5, 127 back-to-back, out_ready 1 → outputs 10,10,10,10,-5,-5,-5,-5,127,127,127,127 on consecutive cycles, first one cycle after the first accept; in_ready high once per 4 cycles.
- Zero-insert mode, inputs 7, -128 → outputs 7,0,0,0,-128,0,0,0; mode toggled mid-emission does not alter the current sample's replicas.
- Backpressure: input 50, out_ready low for 3 cycles after the 2nd replica → out_data 50 and out_valid held, in_ready 0, exactly 4 replicas total delivered.
- Frame marking: 3 samples with in_last on the third → out_last high only on the 12th output, coincident with its transfer.
- Reset mid-emission: rst_n low after 2 replicas of 50 → out_valid 0 immediately; after release, in_ready 1, no residual 50 appears; the next input -3 produces 4 replicas of -3.
- Gaps: one sample 20, then in_valid low → exactly 4 outputs, then IDLE with out_valid 0; a later sample is accepted in the same cycle in_valid rises, with first output the following cycle.
